// File: rtl/feature_map_sink_pkg.sv
// Shared CNN constants for the pooled-result sink: sample width, map geometry, FSM states.
package feature_map_sink_pkg;

  localparam int CNN_DATA_W = 33;
  localparam int CONV_W     = 26;
  localparam int CONV_H     = 26;
  localparam int POOL_W     = CONV_W / 2;
  localparam int POOL_H     = CONV_H / 2;

  typedef enum logic {
    S_FILL = 1'b0,
    S_DROP = 1'b1
  } sink_state_t;

endpackage

// File: rtl/sink_bank_ram.sv
// One frame bank: synchronous write, registered read that holds its value when not read.
module sink_bank_ram #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 169,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/feature_map_sink.sv
// Captures pooled frames into a ping-pong buffer and serves them to a random-access reader;
// whole frames are discarded when both banks are still held by the reader.
//
//   state  | meaning
//   S_FILL | writing samples into bank wr_bank (or waiting for sample 0)
//   S_DROP | discarding the remainder of a frame that found no free bank
module feature_map_sink
  import feature_map_sink_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int MAP_W  = POOL_W,
  parameter int MAP_H  = POOL_H,
  parameter int ADDR_W = $clog2(MAP_W * MAP_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              input_valid,
  input  logic [DATA_W-1:0] input_data,
  output logic              frame_ready,
  output logic              frame_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_release,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam int DEPTH = MAP_W * MAP_H;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  sink_state_t       state, state_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic              rd_bank, rd_bank_nxt;
  logic [1:0]        bank_full, full_nxt;
  logic              wr_en, drop_start, frame_end, release_ok;
  logic              rd_accept, rd_in_range;
  logic              rd_sel, rd_zero;
  logic [DATA_W-1:0] ram_q [2];

  assign rd_accept   = rd_en & frame_ready;
  assign rd_in_range = 32'(rd_addr) < DEPTH;

  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    full_nxt    = bank_full;
    wr_en       = 1'b0;
    drop_start  = 1'b0;
    frame_end   = 1'b0;
    release_ok  = rd_release & frame_ready;

    // Release is applied first so a frame starting on the just-freed bank is kept.
    if (release_ok) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = ~rd_bank;
    end

    if (input_valid) begin
      case (state)
        S_FILL: begin
          if (wr_addr == '0 && full_nxt[wr_bank]) begin
            drop_start = 1'b1;
            if (DEPTH > 1) begin
              state_nxt   = S_DROP;
              wr_addr_nxt = ADDR_W'(1);
            end
          end else begin
            wr_en = 1'b1;
            if (wr_addr == LAST) begin
              full_nxt[wr_bank] = 1'b1;
              frame_end         = 1'b1;
              wr_bank_nxt       = ~wr_bank;
              wr_addr_nxt       = '0;
            end else begin
              wr_addr_nxt = wr_addr + 1'b1;
            end
          end
        end
        S_DROP: begin
          if (wr_addr == LAST) begin
            wr_addr_nxt = '0;
            state_nxt   = S_FILL;
          end else begin
            wr_addr_nxt = wr_addr + 1'b1;
          end
        end
        default: state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= S_FILL;
      wr_addr     <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      bank_full   <= '0;
      frame_ready <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      rd_valid    <= 1'b0;
      rd_sel      <= 1'b0;
      rd_zero     <= 1'b1;  // forces rd_data to 0 until the first accepted read
    end else begin
      state       <= state_nxt;
      wr_addr     <= wr_addr_nxt;
      wr_bank     <= wr_bank_nxt;
      rd_bank     <= rd_bank_nxt;
      bank_full   <= full_nxt;
      frame_ready <= full_nxt[rd_bank_nxt];
      frame_done  <= frame_end;
      rd_valid    <= rd_accept;
      if (drop_start) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      if (rd_accept) begin
        rd_sel  <= rd_bank;
        rd_zero <= ~rd_in_range;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sink_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (IDX_W)
    ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en && (wr_bank == b[0])),
      .wr_addr (wr_addr[IDX_W-1:0]),
      .wr_data (input_data),
      .rd_en   (rd_accept && rd_in_range && (rd_bank == b[0])),
      .rd_addr (rd_addr[IDX_W-1:0]),
      .rd_data (ram_q[b])
    );
  end

  assign rd_data = rd_zero ? '0 : ram_q[rd_sel];

endmodule

// File: tb/tb_feature_map_sink.sv
// Directed bench for feature_map_sink on a 2x2 map: fill, gaps, ping-pong, overflow, collision, reset.
module tb_feature_map_sink;

  localparam int DW = 33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          input_valid = 1'b0;
  logic [DW-1:0] input_data = '0;
  logic          frame_ready, frame_done;
  logic          rd_en = 1'b0;
  logic [2:0]    rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_release = 1'b0;
  logic          overflow;
  logic [7:0]    drop_count;

  int total = 0;
  int bad = 0;

  feature_map_sink #(
    .DATA_W (DW),
    .MAP_W  (2),
    .MAP_H  (2),
    .ADDR_W (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_valid (input_valid),
    .input_data  (input_data),
    .frame_ready (frame_ready),
    .frame_done  (frame_done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_release  (rd_release),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] d(input int v);
    return DW'(v);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    input_valid = 1'b1;
    input_data  = d(v);
    cyc();
    input_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input int a, input logic ev, input int ed);
    rd_en   = 1'b1;
    rd_addr = 3'(a);
    cyc();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'(ev));
    chk({tag, "_data"}, 64'(rd_data), 64'(d(ed)));
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    cyc();
    rd_release = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_frame_ready"}, 64'(frame_ready), 64'(0));
    chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(0));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(0));
  endtask

  initial begin
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    check_idle_outputs("reset");

    // read before any frame is ready is rejected
    rd("early_rd", 0, 1'b0, 0);

    // basic fill into bank 0
    send(1); send(2); send(3);
    chk("fill_done_early", 64'(frame_done), 64'(0));
    send(-4);
    chk("fill_done_pulse", 64'(frame_done), 64'(1));
    chk("fill_ready", 64'(frame_ready), 64'(1));
    cyc();
    chk("fill_done_clear", 64'(frame_done), 64'(0));
    rd("fill_a0", 0, 1'b1, 1);
    rd("fill_a1", 1, 1'b1, 2);
    rd("fill_a2", 2, 1'b1, 3);
    rd("fill_a3", 3, 1'b1, -4);
    rd("oob_a5", 5, 1'b1, 0);
    rd("fill_a3b", 3, 1'b1, -4);
    release_bank();
    chk("rel_ready0", 64'(frame_ready), 64'(0));
    rd("hold_rejected", 1, 1'b0, -4);

    // gapped frame into bank 1
    send(1); cyc(); send(2); cyc(); cyc(); send(3); cyc(); send(-4);
    chk("gap_done", 64'(frame_done), 64'(1));
    chk("gap_ready", 64'(frame_ready), 64'(1));
    rd("gap_a0", 0, 1'b1, 1);
    rd("gap_a1", 1, 1'b1, 2);
    rd("gap_a2", 2, 1'b1, 3);
    rd("gap_a3", 3, 1'b1, -4);
    release_bank();

    // ping-pong A into bank 0, B into bank 1
    send(10); send(11); send(12); send(13);
    send(20); send(21); send(22); send(23);
    rd("pp_a0", 0, 1'b1, 10);
    rd("pp_a3", 3, 1'b1, 13);
    release_bank();
    chk("pp_ready_b", 64'(frame_ready), 64'(1));
    rd("pp_b0", 0, 1'b1, 20);
    rd("pp_b3", 3, 1'b1, 23);
    release_bank();
    chk("pp_ready_none", 64'(frame_ready), 64'(0));

    // overflow: both banks full, frame C is dropped whole
    send(10); send(11); send(12); send(13);
    send(20); send(21); send(22); send(23);
    send(30);
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_count", 64'(drop_count), 64'(1));
    send(31); send(32); send(33);
    chk("ovf_no_done", 64'(frame_done), 64'(0));
    rd("ovf_keep_a0", 0, 1'b1, 10);
    rd("ovf_keep_a1", 1, 1'b1, 11);
    release_bank();
    send(40); send(41); send(42); send(43);
    chk("d_done", 64'(frame_done), 64'(1));
    rd("ovf_b0", 0, 1'b1, 20);
    release_bank();
    rd("d_a0", 0, 1'b1, 40);
    rd("d_a3", 3, 1'b1, 43);
    chk("d_count", 64'(drop_count), 64'(1));

    // collision: bank 1 filled with E, then release bank 0 as F starts on it
    send(50); send(51); send(52); send(53);
    rd_release = 1'b1;
    send(60);
    rd_release = 1'b0;
    send(61); send(62); send(63);
    chk("col_done", 64'(frame_done), 64'(1));
    chk("col_count", 64'(drop_count), 64'(1));
    rd("col_e0", 0, 1'b1, 50);
    rd_en = 1'b1;
    rd_addr = 3'd1;
    rd_release = 1'b1;
    cyc();
    rd_en = 1'b0;
    rd_release = 1'b0;
    chk("rel_rd_old_valid", 64'(rd_valid), 64'(1));
    chk("rel_rd_old_data", 64'(rd_data), 64'(d(51)));
    rd("col_f0", 0, 1'b1, 60);
    rd("col_f3", 3, 1'b1, 63);

    // reset mid-frame
    send(70); send(71);
    rst_n = 1'b1;
    cyc();
    rst_n = 1'b0;
    check_idle_outputs("mid_reset");
    send(7); send(8); send(9); send(10);
    chk("post_rst_done", 64'(frame_done), 64'(1));
    chk("post_rst_ready", 64'(frame_ready), 64'(1));
    rd("post_rst_a0", 0, 1'b1, 7);
    rd("post_rst_a1", 1, 1'b1, 8);
    rd("post_rst_a2", 2, 1'b1, 9);
    rd("post_rst_a3", 3, 1'b1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feature_map_sink.md
Name: feature_map_sink

Overview:
- Receiving end of the valid/data result stream leaving the pooling stage: captures each complete pooled feature map into an on-chip ping-pong buffer.
- Exposes each buffered frame to a downstream reader (PS bridge or FC layer) through a random-access read port.
- Keeps frame alignment when the reader falls behind by discarding whole frames, never partial ones.

Parameters:
- DATA_W, 33, width of one pooled sample (signed, two's complement).
- MAP_W, 13, feature-map width in samples.
- MAP_H, 13, feature-map height in samples.
- DEPTH, MAP_W*MAP_H, samples per frame; derived, not overridden.
- ADDR_W, $clog2(DEPTH), read/write address width.

Ports:
- clk  in  1  sole clock. One clock; reset is synchronous and active-high.
- rst_n  in  1  synchronous reset, asserted high despite the suffix.
- input_valid  in  1  a sample is present on input_data this cycle; no backpressure.
- input_data  in  DATA_W  pooled sample, raster order.
- frame_ready  out  1  a complete frame is readable.
- frame_done  out  1  one-cycle pulse when a frame finishes writing.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address within the current read bank.
- rd_valid  out  1  rd_data valid; asserted one cycle after an accepted rd_en.
- rd_data  out  DATA_W  read result.
- rd_release  in  1  reader finished with the current bank.
- overflow  out  1  sticky: at least one frame was dropped.
- drop_count  out  8  dropped frames, saturates at 255.

Behaviour:
- Storage and status: two banks of DEPTH x DATA_W, bank_full[1:0], wr_bank, wr_addr, rd_bank.
- Reset values: all outputs 0, bank_full=0, wr_bank=0, rd_bank=0, wr_addr=0, state S_FILL. Memory contents are not cleared.
- FSM S_FILL:
  - On input_valid, write input_data to bank[wr_bank][wr_addr].
  - Normally wr_addr++.
  - At wr_addr==DEPTH-1: set bank_full[wr_bank], pulse frame_done next cycle, toggle wr_bank, set wr_addr=0.
- Frame-start check: when input_valid arrives with wr_addr==0 and bank_full[wr_bank]==1 (after applying any same-cycle release):
  - Do not write; go to S_DROP with wr_addr=1.
  - Set overflow=1; drop_count++ (saturating).
  - If DEPTH==1, the drop completes in this same cycle and the FSM stays in S_FILL.
- FSM S_DROP:
  - Count input_valid samples without writing.
  - At wr_addr==DEPTH-1: set wr_addr=0, return to S_FILL. wr_bank is unchanged.
  - A frame that has started writing always completes into its bank.
- frame_ready = bank_full[rd_bank], registered.
- Read port:
  - rd_en is accepted only when frame_ready==1.
  - One-cycle latency: rd_valid=1 and rd_data=bank[rd_bank][rd_addr].
  - rd_addr>=DEPTH returns rd_data=0 with rd_valid=1.
  - A rejected rd_en gives rd_valid=0 and rd_data holds its previous value.
- rd_release:
  - With frame_ready=1: clear bank_full[rd_bank], toggle rd_bank.
  - With frame_ready=0: ignored.
  - rd_en in the same cycle as rd_release still reads the old bank.
- Simultaneous release and frame-start on the same bank: the release wins and the sample is written (no drop).
- Simultaneous final write and release of different banks: both take effect.
- Input ordering: frames complete in bank order 0,1,0,1…; rd_bank follows the same order.
- Reset mid-frame: the partial frame is discarded, all state returns to reset values, and the first valid after reset is sample 0 of a new frame.
- No arithmetic on data; input_data is stored bit-exact.

Decomposition:
- Shared CNN package holds:
  - DATA_W=33 and map-geometry constants (conv 26x26 -> pool 13x13).
  - FSM state encoding S_FILL/S_DROP.
- Natural sub-module: sink_bank_ram, a single-port-write / single-port-read synchronous RAM with 1-cycle read latency and DEPTH x DATA_W geometry, instantiated twice.
- Bank select, FSM, counters and status stay in feature_map_sink.

Test Plan:
- Basic fill (MAP_W=MAP_H=2, DEPTH=4): stream 1,2,3,-4 in back-to-back cycles.
  - frame_done pulses once, one cycle after the 4th valid; frame_ready=1.
  - Reads of addr 0..3 return 1,2,3,-4 (33-bit sign-extended) one cycle after each rd_en.
- Gapped input: the same frame sent with idle cycles between valids produces identical stored data.
  - rd_en before frame_ready gives rd_valid=0.
  - rd_addr=5 gives rd_data=0 with rd_valid=1.
- Ping-pong: send frames A=10..13 and B=20..23 with no release.
  - Both banks are full; reads return A.
  - rd_release, then reads return B.
  - A second rd_release gives frame_ready=0.
- Overflow: fill both banks, then send frame C=30..33.
  - No writes occur; overflow=1, drop_count=1.
  - Release once, send D=40..43: D lands in bank 0 and reads back after B is released.
- Release/start collision: both banks full, rd_release asserted in the same cycle as sample 0 of a new frame.
  - The frame is written and drop_count is unchanged.
- Reset mid-frame: assert rst_n=1 after 2 samples.
  - All outputs are 0; a new 4-sample frame 7,8,9,10 reads back correctly from bank 0.
